// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared constants for the instruction-fetch stage of the 8-bit processor.
//   ADDR_W      : program-counter / instruction-memory address width
//   INSTR_W     : instruction word width
//   INSTR_DEPTH : number of instruction words (2**ADDR_W)
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int ADDR_W      = 6;
  localparam int INSTR_W     = 16;
  localparam int INSTR_DEPTH = 64;

  // Next sequential address; the natural ADDR_W-bit overflow gives 63 -> 0.
  function automatic logic [ADDR_W-1:0] pc_plus_one(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
//   64 x 16 ROM-like instruction store with asynchronous (combinational) read.
//   There is no write port; contents are preloaded by simulation or synthesis
//   initialisation into the array 'instrmem', and are never touched by reset.
// Ports
//   addr  : in  ADDR_W   read address
//   rdata : out INSTR_W  word stored at addr (zero-latency)
// -----------------------------------------------------------------------------
module inst_mem
  import inst_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] instrmem [INSTR_DEPTH];

  assign rdata = instrmem[addr];

endmodule : inst_mem

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage: holds the program counter and presents the
//   instruction word stored at PC.
// Ports
//   clk         : in  1        system clock, PC updates on rising edge
//   reset       : in  1        asynchronous active-low reset (PC -> 0)
//   enable      : in  1        gates PC updates and the instruction output
//   loadPC      : in  1        load PC from address (wins over incPC)
//   incPC       : in  1        increment PC (modulo 64)
//   address     : in  ADDR_W   jump/branch target
//   instruction : out INSTR_W  mem[PC] when enabled, else 0
//   pc          : out ADDR_W   current PC
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               loadPC,
  input  logic               incPC,
  input  logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [INSTR_W-1:0] mem_rdata;

  // Next-PC mux: enable gates everything, load beats increment.
  always_comb begin
    pc_d = pc_q;
    if (enable) begin
      if (loadPC) begin
        pc_d = address;
      end else if (incPC) begin
        pc_d = pc_plus_one(pc_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  inst_mem instmem_inst (
    .addr  (pc_q),
    .rdata (mem_rdata)
  );

  assign pc          = pc_q;
  assign instruction = enable ? mem_rdata : '0;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch: table of directed vectors, hand-written
//   asynchronous-reset sequences and a randomized run against a reference
//   model of the program counter.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               loadPC;
  logic               incPC;
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pc;

  int total;
  int bad;

  // Reference state: PC as a plain integer and a private copy of the ROM image.
  int          model_pc;
  logic [15:0] tb_mem [64];

  typedef struct {
    logic        en;
    logic        ld;
    logic        inc;
    logic [5:0]  addr;
    int          exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [12];

  inst_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .loadPC      (loadPC),
    .incPC       (incPC),
    .address     (address),
    .instruction (instruction),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%0h", name, actual);
    end
  endtask

  function automatic logic [15:0] exp_instr_of(input logic en, input int p);
    return en ? tb_mem[p] : 16'h0000;
  endfunction

  // Inputs change just after the active edge; outputs sampled #1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = 16'h0100 + 16'(i);
      dut.instmem_inst.instrmem[i] = 16'h0100 + 16'(i);
    end

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 6'd7,  7,  16'h0107}; // load
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 6'd0,  8,  16'h0108}; // increment
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd0,  8,  16'h0108}; // hold
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 6'd63, 63, 16'h013F}; // load beats inc
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 6'd0,  0,  16'h0100}; // wrap 63 -> 0
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 6'd0,  0,  16'h0000}; // gated x3
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 6'd0,  0,  16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'd0,  0,  16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd0,  0,  16'h0100}; // output returns
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'd5,  0,  16'h0000}; // gated load
    vecs[10] = '{1'b1, 1'b0, 1'b1, 6'd9,  1,  16'h0101}; // address ignored
    vecs[11] = '{1'b1, 1'b1, 1'b0, 6'd40, 40, 16'h0128};

    // Reset with enable high: visible without any clock edge.
    enable  = 1'b1;
    loadPC  = 1'b0;
    incPC   = 1'b0;
    address = '0;
    reset   = 1'b0;
    #2;
    check("reset_pc", int'(pc), 0);
    check("reset_instr", int'(instruction), 16'h0100);
    step();
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      enable  = vecs[i].en;
      loadPC  = vecs[i].ld;
      incPC   = vecs[i].inc;
      address = vecs[i].addr;
      step();
      check($sformatf("vec%0d_pc", i), int'(pc), vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), int'(instruction), int'(vecs[i].exp_instr));
    end

    // Async reset mid-run: load 8, then pull reset between edges.
    enable = 1'b1; loadPC = 1'b1; incPC = 1'b0; address = 6'd8;
    step();
    check("pre_rst_pc", int'(pc), 8);
    loadPC = 1'b0; incPC = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc", int'(pc), 0);
    check("async_rst_instr", int'(instruction), 16'h0100);
    step();
    check("held_rst_pc", int'(pc), 0);
    reset = 1'b1;
    step();
    check("post_rst_inc_pc", int'(pc), 1);
    check("post_rst_inc_instr", int'(instruction), 16'h0101);

    // Randomized run against the reference model.
    model_pc = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        #1;
        model_pc = 0;
        check($sformatf("rnd%0d_rst_pc", n), int'(pc), model_pc);
        reset = 1'b1;
      end
      enable  = ($urandom_range(0, 3) != 0);
      loadPC  = ($urandom_range(0, 3) == 0);
      incPC   = ($urandom_range(0, 1) == 1);
      address = 6'($urandom_range(0, 63));
      step();
      if (enable) begin
        if (loadPC)     model_pc = int'(address);
        else if (incPC) model_pc = (model_pc + 1) % 64;
      end
      check($sformatf("rnd%0d_pc", n), int'(pc), model_pc);
      check($sformatf("rnd%0d_instr", n), int'(instruction),
            int'(exp_instr_of(enable, model_pc)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_inst_fetch
